// File: rtl/rtc_timer_if.sv
// Data-bus bundle between the core and the machine timer.
// The core drives the request side; the timer returns registered read data.
interface rtc_timer_if;
  logic        en_i;
  logic [3:0]  addr_i;
  logic [7:0]  we_i;
  logic [63:0] data_i;
  logic [63:0] data_o;

  modport master (output en_i, output addr_i, output we_i, output data_i, input data_o);
  modport slave  (input en_i, input addr_i, input we_i, input data_i, output data_o);
endinterface

// File: rtl/rtc_timer.sv
// RISC-V machine timer: free-running 64-bit mtime, 64-bit mtimecmp and the MTI level.
// Byte-lane writes, one-cycle registered reads that return pre-update contents.
module rtc_timer (
  input  logic        clk,
  input  logic        reset,
  rtc_timer_if.slave  bus,
  output logic        mti_o,
  output logic [63:0] mtime_o
);

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic [63:0] data_r;

  logic [63:0] lane_mask_s;
  logic [63:0] wdata_s;
  logic [63:0] rsel_s;
  logic [63:0] rdata_s;
  logic        wr_s;
  logic        mtime_wr_s;
  logic        cmp_wr_s;
  logic        unused_addr_s;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [63:0] mask_v);
    byte_merge = (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

  function automatic logic [63:0] expand_lanes(input logic [7:0] lanes);
    for (int k = 0; k < 8; k++) begin
      expand_lanes[8*k +: 8] = {8{lanes[k]}};
    end
  endfunction

  assign unused_addr_s = ^bus.addr_i[1:0];

  // Steer lane enables and write data onto the byte positions of the target register
  always_comb begin
    lane_mask_s = 64'h0;
    wdata_s     = 64'h0;
    if (bus.addr_i[2]) begin
      lane_mask_s = {expand_lanes({4'h0, bus.we_i[3:0]})[31:0], 32'h0};
      wdata_s     = {bus.data_i[31:0], 32'h0};
    end else begin
      lane_mask_s = expand_lanes(bus.we_i);
      wdata_s     = bus.data_i;
    end
  end

  // Only a write that actually touches a byte of mtime suppresses the increment
  assign wr_s       = bus.en_i & (bus.we_i != 8'h00);
  assign mtime_wr_s = wr_s & ~bus.addr_i[3] & (lane_mask_s != 64'h0);
  assign cmp_wr_s   = wr_s &  bus.addr_i[3] & (lane_mask_s != 64'h0);

  // Read mux: upper-word reads are right-justified for 32-bit masters
  always_comb begin
    rsel_s  = bus.addr_i[3] ? mtimecmp_r : mtime_r;
    rdata_s = 64'h0;
    if (bus.addr_i[2]) begin
      rdata_s = {32'h0, rsel_s[63:32]};
    end else begin
      rdata_s = rsel_s;
    end
  end

  // mtime counter with byte-write override
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_r <= 64'h0;
    end else if (mtime_wr_s) begin
      mtime_r <= byte_merge(mtime_r, wdata_s, lane_mask_s);
    end else begin
      mtime_r <= mtime_r + 64'h1;
    end
  end

  // mtimecmp changes only on writes
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (cmp_wr_s) begin
      mtimecmp_r <= byte_merge(mtimecmp_r, wdata_s, lane_mask_s);
    end else begin
      mtimecmp_r <= mtimecmp_r;
    end
  end

  // Registered read data, held while the block is not selected
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= 64'h0;
    end else if (bus.en_i) begin
      data_r <= rdata_s;
    end else begin
      data_r <= data_r;
    end
  end

  assign bus.data_o = data_r;
  assign mtime_o    = mtime_r;
  assign mti_o      = (mtime_r >= mtimecmp_r);

endmodule

// File: tb/tb_rtc_timer.sv
// Directed bench for rtc_timer: a per-cycle vector table plus hand-written reset sequences.
module tb_rtc_timer;
  logic        clk;
  logic        reset;
  logic        mti_o;
  logic [63:0] mtime_o;
  int          n_total;
  int          n_pass;

  rtc_timer_if bus ();

  rtc_timer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .mti_o   (mti_o),
    .mtime_o (mtime_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  addr;
    logic [7:0]  we;
    logic [63:0] data;
    logic [63:0] exp_mtime;
    logic        exp_mti;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return at the next falling edge
  task automatic apply(input logic en, input logic [3:0] a, input logic [7:0] w, input logic [63:0] d);
    bus.en_i   = en;
    bus.addr_i = a;
    bus.we_i   = w;
    bus.data_i = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [63:0] em, input logic ei, input logic [63:0] ed);
    check({tag, "_mtime"}, mtime_o, em);
    check({tag, "_mti"}, {63'h0, mti_o}, {63'h0, ei});
    check({tag, "_data"}, bus.data_o, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    //          en    addr   we     data                    mtime                   mti   data_o
    vecs[0]  = '{1'b1, 4'h8, 8'h00, 64'h0,                  64'd11,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1]  = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'd12,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{1'b1, 4'hC, 8'h00, 64'h0,                  64'd13,                 1'b0, 64'h0000_0000_FFFF_FFFF};
    vecs[3]  = '{1'b1, 4'h8, 8'h0F, 64'h20,                 64'd14,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{1'b1, 4'hC, 8'h0F, 64'h0,                  64'd15,                 1'b0, 64'h0000_0000_FFFF_FFFF};
    vecs[5]  = '{1'b1, 4'h0, 8'hFF, 64'h1E,                 64'h1E,                 1'b0, 64'h0F};
    vecs[6]  = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h1F,                 1'b0, 64'h0F};
    vecs[7]  = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h20,                 1'b1, 64'h0F};
    vecs[8]  = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h21,                 1'b1, 64'h0F};
    vecs[9]  = '{1'b1, 4'hC, 8'h0F, 64'h1,                  64'h22,                 1'b0, 64'h0};
    vecs[10] = '{1'b1, 4'h0, 8'h0F, 64'hFFFF_FFFE,          64'h0000_0000_FFFF_FFFE, 1'b0, 64'h22};
    vecs[11] = '{1'b1, 4'h4, 8'h0F, 64'hFFFF_FFFF,          64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'h0};
    vecs[12] = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
    vecs[13] = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h0,                  1'b0, 64'h0};
    vecs[14] = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h1,                  1'b0, 64'h0};
    vecs[15] = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h2,                  1'b0, 64'h0};
    vecs[16] = '{1'b1, 4'h0, 8'hFF, 64'h1234_5678,          64'h1234_5678,          1'b0, 64'h2};
    vecs[17] = '{1'b1, 4'h0, 8'h02, 64'hAB00,               64'h1234_AB78,          1'b0, 64'h1234_5678};
    vecs[18] = '{1'b0, 4'h0, 8'h00, 64'h0,                  64'h1234_AB79,          1'b0, 64'h1234_5678};
    vecs[19] = '{1'b1, 4'h0, 8'hFF, 64'h0000_0003_0000_0010, 64'h0000_0003_0000_0010, 1'b1, 64'h1234_AB79};
    vecs[20] = '{1'b1, 4'h4, 8'h00, 64'h0,                  64'h0000_0003_0000_0011, 1'b1, 64'h3};
    vecs[21] = '{1'b1, 4'h4, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0003_0000_0012, 1'b1, 64'h3};
    vecs[22] = '{1'b0, 4'h0, 8'hFF, 64'h0,                  64'h0000_0003_0000_0013, 1'b1, 64'h3};
    vecs[23] = '{1'b1, 4'h8, 8'hFF, 64'h0,                  64'h0000_0003_0000_0014, 1'b1, 64'h0000_0001_0000_0020};
    vecs[24] = '{1'b1, 4'h8, 8'hF0, 64'h0000_0005_0000_0000, 64'h0000_0003_0000_0015, 1'b0, 64'h0};
    vecs[25] = '{1'b1, 4'h8, 8'hFF, 64'h0,                  64'h0000_0003_0000_0016, 1'b1, 64'h0000_0005_0000_0000};

    reset      = 1'b1;
    bus.en_i   = 1'b0;
    bus.addr_i = 4'h0;
    bus.we_i   = 8'h00;
    bus.data_i = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 64'h0, 1'b0, 64'h0);

    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 4'h0, 8'h00, 64'h0);
    end
    check_all("idle10", 64'd10, 1'b0, 64'h0);

    for (int i = 0; i < 26; i++) begin
      apply(vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].data);
      check_all($sformatf("v%0d", i), vecs[i].exp_mtime, vecs[i].exp_mti, vecs[i].exp_data);
    end

    // Reset while mti is high and a write is in flight: the write is discarded
    reset = 1'b1;
    apply(1'b1, 4'h0, 8'hFF, 64'h55);
    check_all("rst_mid", 64'h0, 1'b0, 64'h0);

    // First edge after reset release counts and reads the restored compare value
    reset = 1'b0;
    apply(1'b1, 4'h8, 8'h00, 64'h0);
    check_all("post_rst", 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    apply(1'b0, 4'h0, 8'h00, 64'h0);
    check_all("post_rst_hold", 64'h2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
